// File: rtl/sr_latch_bank.sv
// sr_latch_bank: a bank of CHANNELS clocked WIDTH-bit flag registers.
// Each channel can be loaded whole or edited bit-by-bit with set/reset masks.
// A key-protected lock (A5 then 5A) freezes all contents while engaged.
// Change detection (CHANGED) and error signalling (ERR) are one-cycle pulses.
// Every output comes straight from a flop.
module sr_latch_bank #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      CHANNELS      = 4,
  parameter int unsigned      CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter bit               LOCK_ON_RESET = 1'b0,
  localparam int unsigned     SEL_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic                      i_en,
  input  logic [WIDTH-1:0]          i_d,
  input  logic                      i_sr_en,
  input  logic [WIDTH-1:0]          i_s,
  input  logic [WIDTH-1:0]          i_r,
  input  logic                      i_lock,
  input  logic                      i_key_valid,
  input  logic [7:0]                i_key,
  output logic [CHANNELS*WIDTH-1:0] o_q,
  output logic [CHANNELS*WIDTH-1:0] o_q_bar,
  output logic [CHANNELS-1:0]       o_changed,
  output logic                      o_locked,
  output logic                      o_err
);

  // The unlock sequence is two consecutive key bytes.
  localparam logic [7:0] KEY_FIRST  = 8'hA5;
  localparam logic [7:0] KEY_SECOND = 8'h5A;

  // The lock states. ARMED means the first key byte was accepted.
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_ARMED    = 2'd2
  } lock_state_t;

  localparam lock_state_t ST_RESET = LOCK_ON_RESET ? ST_LOCKED : ST_UNLOCKED;

  // This function computes the set/reset result for one channel.
  // When S and R are both high on a bit, CONFLICT_MODE picks the result:
  // 0 keeps the old value, 1 makes the bit 1, and 2 makes the bit 0.
  function automatic logic [WIDTH-1:0] apply_sr(
    input logic [WIDTH-1:0] old_v,
    input logic [WIDTH-1:0] s_v,
    input logic [WIDTH-1:0] r_v
  );
    logic [WIDTH-1:0] res_v;
    res_v = old_v;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      case ({s_v[b], r_v[b]})
        2'b10:   res_v[b] = 1'b1;
        2'b01:   res_v[b] = 1'b0;
        2'b11: begin
          case (CONFLICT_MODE)
            32'd1:   res_v[b] = 1'b1;
            32'd2:   res_v[b] = 1'b0;
            default: res_v[b] = old_v[b];
          endcase
        end
        default: res_v[b] = old_v[b];
      endcase
    end
    return res_v;
  endfunction

  lock_state_t                r_state;
  lock_state_t                w_state_nxt;
  logic                       w_key_err;

  logic [CHANNELS*WIDTH-1:0]  r_q;
  logic [CHANNELS*WIDTH-1:0]  r_q_bar;
  logic [CHANNELS-1:0]        r_changed;
  logic                       r_locked;
  logic                       r_err;

  logic [CHANNELS*WIDTH-1:0]  w_q_nxt;
  logic [CHANNELS-1:0]        w_changed_nxt;
  logic                       w_req;
  logic                       w_sel_ok;
  logic                       w_wr_ok;
  logic                       w_acc_err;

  // A write attempt is legal only when the bank is unlocked and SEL is in range.
  assign w_req     = i_en | i_sr_en;
  assign w_sel_ok  = (32'(i_sel) < CHANNELS);
  assign w_wr_ok   = w_req & w_sel_ok & (r_state == ST_UNLOCKED);
  assign w_acc_err = w_req & ~(w_sel_ok & (r_state == ST_UNLOCKED));

  // Lock FSM state register. The reset state depends on LOCK_ON_RESET.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock FSM next state and key error.
  // LOCK has priority over key handling in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_key_err   = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        if (i_lock) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (i_lock) begin
          w_state_nxt = ST_LOCKED;
        end else if (i_key_valid) begin
          if (i_key == KEY_FIRST) begin
            w_state_nxt = ST_ARMED;
          end else begin
            w_state_nxt = ST_LOCKED;
            w_key_err   = 1'b1;
          end
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_ARMED: begin
        if (i_lock) begin
          w_state_nxt = ST_LOCKED;
        end else if (i_key_valid) begin
          if (i_key == KEY_SECOND) begin
            w_state_nxt = ST_UNLOCKED;
          end else begin
            w_state_nxt = ST_LOCKED;
            w_key_err   = 1'b1;
          end
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        // An unreachable encoding falls back to the protected state.
        w_state_nxt = ST_LOCKED;
      end
    endcase
  end

  // Next channel contents and per-channel change flags.
  // EN takes priority over SR_EN. Unselected channels hold their value.
  always_comb begin
    w_q_nxt       = r_q;
    w_changed_nxt = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (w_wr_ok && (32'(i_sel) == c)) begin
        if (i_en) begin
          w_q_nxt[c*WIDTH +: WIDTH] = i_d;
        end else begin
          w_q_nxt[c*WIDTH +: WIDTH] = apply_sr(r_q[c*WIDTH +: WIDTH], i_s, i_r);
        end
      end else begin
        w_q_nxt[c*WIDTH +: WIDTH] = r_q[c*WIDTH +: WIDTH];
      end
      w_changed_nxt[c] = (w_q_nxt[c*WIDTH +: WIDTH] != r_q[c*WIDTH +: WIDTH]);
    end
  end

  // Output registers.
  // Q_BAR has its own flop so that it never depends on a comb path from Q.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q       <= {CHANNELS{RESET_VALUE}};
      r_q_bar   <= ~{CHANNELS{RESET_VALUE}};
      r_changed <= '0;
      r_locked  <= LOCK_ON_RESET;
      r_err     <= 1'b0;
    end else begin
      r_q       <= w_q_nxt;
      r_q_bar   <= ~w_q_nxt;
      r_changed <= w_changed_nxt;
      r_locked  <= (w_state_nxt != ST_UNLOCKED);
      r_err     <= w_acc_err | w_key_err;
    end
  end

  assign o_q       = r_q;
  assign o_q_bar   = r_q_bar;
  assign o_changed = r_changed;
  assign o_locked  = r_locked;
  assign o_err     = r_err;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Bench for sr_latch_bank. Three instances share one stimulus stream:
// mode 0 with 4 channels, mode 1 with 4 channels, and mode 2 with 3 channels.
// A behavioural model predicts every output, and assertions compare each cycle.
module tb_sr_latch_bank;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic       en;
  logic       sr_en;
  logic       lock;
  logic       kv;
  logic [7:0] d;
  logic [7:0] s;
  logic [7:0] r;
  logic [7:0] key;

  logic [31:0] q0, qb0, q1, qb1;
  logic [23:0] q2, qb2;
  logic [3:0]  ch0, ch1;
  logic [2:0]  ch2;
  logic        lk0, lk1, lk2, er0, er1, er2;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: stored bytes per instance/channel, plus the lock status.
  logic [7:0] m_q [3][4];
  logic [3:0] m_chg [3];
  bit         m_err [3];
  bit         m_locked;
  bit         m_armed;

  sr_latch_bank #(.WIDTH(8), .CHANNELS(4), .CONFLICT_MODE(0), .RESET_VALUE(8'h3C), .LOCK_ON_RESET(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_en(en), .i_d(d), .i_sr_en(sr_en), .i_s(s), .i_r(r),
    .i_lock(lock), .i_key_valid(kv), .i_key(key),
    .o_q(q0), .o_q_bar(qb0), .o_changed(ch0), .o_locked(lk0), .o_err(er0));

  sr_latch_bank #(.WIDTH(8), .CHANNELS(4), .CONFLICT_MODE(1), .RESET_VALUE(8'h3C), .LOCK_ON_RESET(1'b0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_en(en), .i_d(d), .i_sr_en(sr_en), .i_s(s), .i_r(r),
    .i_lock(lock), .i_key_valid(kv), .i_key(key),
    .o_q(q1), .o_q_bar(qb1), .o_changed(ch1), .o_locked(lk1), .o_err(er1));

  sr_latch_bank #(.WIDTH(8), .CHANNELS(3), .CONFLICT_MODE(2), .RESET_VALUE(8'h3C), .LOCK_ON_RESET(1'b0)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_en(en), .i_d(d), .i_sr_en(sr_en), .i_s(s), .i_r(r),
    .i_lock(lock), .i_key_valid(kv), .i_key(key),
    .o_q(q2), .o_q_bar(qb2), .o_changed(ch2), .o_locked(lk2), .o_err(er2));

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_q(input int k, input int n, input bit inv);
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < n; c++) v[c*8 +: 8] = inv ? ~m_q[k][c] : m_q[k][c];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) m_q[k][c] = 8'h3C;
      m_chg[k] = 4'h0;
      m_err[k] = 1'b0;
    end
    m_locked = 1'b0;
    m_armed  = 1'b0;
  endtask

  // Model of one clock edge. It is derived from the lock rules and the per-bit write rules.
  task automatic model_edge();
    bit         was_locked;
    bit         key_err;
    int         nch;
    logic [7:0] old_v, new_v;
    was_locked = m_locked;
    key_err    = 1'b0;
    if (lock) begin
      m_locked = 1'b1;
      m_armed  = 1'b0;
    end else if (m_locked && !m_armed) begin
      if (kv) begin
        if (key == 8'hA5) m_armed = 1'b1;
        else key_err = 1'b1;
      end
    end else if (m_armed) begin
      if (kv && key == 8'h5A) m_locked = 1'b0;
      else if (kv) key_err = 1'b1;
      m_armed = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      nch = (k == 2) ? 3 : 4;
      m_chg[k] = 4'h0;
      m_err[k] = key_err;
      if (en || sr_en) begin
        if (was_locked || int'(sel) >= nch) begin
          m_err[k] = 1'b1;
        end else begin
          old_v = m_q[k][sel];
          if (en) begin
            new_v = d;
          end else begin
            new_v = (old_v | (s & ~r)) & ~(r & ~s);
            if (k == 1) new_v = new_v | (s & r);
            if (k == 2) new_v = new_v & ~(s & r);
          end
          m_q[k][sel] = new_v;
          m_chg[k][sel] = (new_v != old_v);
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/q0"},   64'(q0),  64'(exp_q(0, 4, 1'b0)));
    chk({tag, "/qb0"},  64'(qb0), 64'(exp_q(0, 4, 1'b1)));
    chk({tag, "/q1"},   64'(q1),  64'(exp_q(1, 4, 1'b0)));
    chk({tag, "/qb1"},  64'(qb1), 64'(exp_q(1, 4, 1'b1)));
    chk({tag, "/q2"},   64'(q2),  64'(exp_q(2, 3, 1'b0)));
    chk({tag, "/qb2"},  64'(qb2), 64'(exp_q(2, 3, 1'b1)));
    chk({tag, "/chg0"}, 64'(ch0), 64'(m_chg[0]));
    chk({tag, "/chg1"}, 64'(ch1), 64'(m_chg[1]));
    chk({tag, "/chg2"}, 64'(ch2), 64'(m_chg[2][2:0]));
    chk({tag, "/lk0"},  64'(lk0), 64'(m_locked));
    chk({tag, "/lk1"},  64'(lk1), 64'(m_locked));
    chk({tag, "/lk2"},  64'(lk2), 64'(m_locked));
    chk({tag, "/err0"}, 64'(er0), 64'(m_err[0]));
    chk({tag, "/err1"}, 64'(er1), 64'(m_err[1]));
    chk({tag, "/err2"}, 64'(er2), 64'(m_err[2]));
  endtask

  task automatic step(input string tag, input logic en_v, input logic sr_v, input logic [1:0] sel_v,
                      input logic [7:0] d_v, input logic [7:0] s_v, input logic [7:0] r_v,
                      input logic lock_v, input logic kv_v, input logic [7:0] key_v);
    en = en_v; sr_en = sr_v; sel = sel_v; d = d_v; s = s_v; r = r_v;
    lock = lock_v; kv = kv_v; key = key_v;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic keyb(input string tag, input logic [7:0] k);
    step(tag, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, k);
  endtask

  // Assert reset mid-cycle and check that the outputs clear without a clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    en = 1'b0; sr_en = 1'b0; lock = 1'b0; kv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed steps from the test plan, then a randomized run.
  initial begin
    rst = 1'b1; en = 1'b0; sr_en = 1'b0; sel = 2'd0; d = 8'h00; s = 8'h00; r = 8'h00;
    lock = 1'b0; kv = 1'b0; key = 8'h00;
    model_reset();
    #3;
    check_all("reset");
    chk("reset_q0_const", 64'(q0), 64'(32'h3C3C3C3C));
    chk("reset_qb0_const", 64'(qb0), 64'(32'hC3C3C3C3));
    @(negedge clk);
    rst = 1'b0;

    // Load sequence, including a repeated write of identical data.
    step("load", 1'b1, 1'b0, 2'd2, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("load_q_const", 64'(q0[23:16]), 64'(8'hA5));
    chk("load_chg_const", 64'(ch0), 64'(4'b0100));
    step("reload", 1'b1, 1'b0, 2'd2, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("reload_chg_const", 64'(ch0), 64'(4'b0000));

    // Set/reset conflict policies on channel 1.
    step("ld0f", 1'b1, 1'b0, 2'd1, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    step("sr", 1'b0, 1'b1, 2'd1, 8'h00, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h00);
    chk("sr_mode0_const", 64'(q0[15:8]), 64'(8'hC3));
    chk("sr_mode1_const", 64'(q1[15:8]), 64'(8'hF3));
    chk("sr_mode2_const", 64'(q2[15:8]), 64'(8'hC3));
    step("en_sr", 1'b1, 1'b1, 2'd1, 8'h5A, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("en_prio_const", 64'(q1[15:8]), 64'(8'h5A));

    // Lock: the write in the same cycle lands, and the next write is rejected.
    step("lock_wr", 1'b1, 1'b0, 2'd0, 8'h11, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("lock_wr_const", 64'(q0[7:0]), 64'(8'h11));
    chk("lock_lk_const", 64'(lk0), 64'(1'b1));
    step("locked_wr", 1'b1, 1'b0, 2'd0, 8'h22, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("locked_wr_const", 64'(q0[7:0]), 64'(8'h11));
    chk("locked_err_const", 64'(er0), 64'(1'b1));
    idle("locked_idle");
    chk("err_once_const", 64'(er0), 64'(1'b0));

    // Unlock sequences, including a wrong second key and a gap between keys.
    keyb("key_a5", 8'hA5);
    keyb("key_5a", 8'h5A);
    chk("unlock_const", 64'(lk0), 64'(1'b0));
    step("relock", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    keyb("bad_a5", 8'hA5);
    keyb("bad_77", 8'h77);
    chk("bad_key_lk_const", 64'(lk0), 64'(1'b1));
    chk("bad_key_err_const", 64'(er0), 64'(1'b1));
    keyb("gap_a5", 8'hA5);
    idle("gap_idle");
    keyb("gap_5a", 8'h5A);
    chk("gap_lk_const", 64'(lk0), 64'(1'b1));
    keyb("re_a5", 8'hA5);
    keyb("re_5a", 8'h5A);

    // An out-of-range SEL errors only on the 3-channel instance.
    step("oor", 1'b1, 1'b0, 2'd3, 8'h99, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("oor_err_const", 64'(er2), 64'(1'b1));
    chk("oor_q2_chg_const", 64'(ch2), 64'(3'b000));

    // Reset while ARMED.
    step("arm_lock", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    keyb("arm_a5", 8'hA5);
    do_reset("rst_armed");
    chk("rst_armed_lk_const", 64'(lk0), 64'(1'b0));
    chk("rst_armed_q_const", 64'(q0), 64'(32'h3C3C3C3C));

    // Randomized traffic, with an occasional asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] kr;
      case ($urandom_range(0, 2))
        0:       kr = 8'hA5;
        1:       kr = 8'h5A;
        default: kr = 8'($urandom);
      endcase
      step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 2'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 1) == 1), kr);
      if (i % 137 == 136) do_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_latch_bank.md
# sr_latch_bank

Parametrised bank of CHANNELS clocked WIDTH-bit registers. Each bit can be loaded, set or reset, with a selectable policy for simultaneous set and reset. A key-protected lock freezes all contents. The block generalises the single-bit SR, D and gated storage elements into the storage used for control and status flags, and adds change detection and error signalling.

## Interface
- WIDTH, 8: bits per channel (1..32).
- CHANNELS, 4: number of channels (1..16). SEL_W = max(1, clog2(CHANNELS)).
- CONFLICT_MODE, 0: per-bit S&R policy. 0 = hold, 1 = set wins, 2 = reset wins.
- RESET_VALUE, 0: WIDTH-bit value loaded into every channel on reset.
- LOCK_ON_RESET, 0: 1 = lock FSM leaves reset in LOCKED.

- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- SEL  in  SEL_W  target channel for EN/SR_EN.
- EN  in  1  load D into channel SEL.
- D  in  WIDTH  load data.
- SR_EN  in  1  apply S/R masks to channel SEL.
- S  in  WIDTH  per-bit set mask.
- R  in  WIDTH  per-bit reset mask.
- LOCK  in  1  request lock (level, sampled each cycle).
- KEY_VALID  in  1  KEY is presented this cycle.
- KEY  in  8  unlock key byte.
- Q  out  CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH].
- Q_BAR  out  CHANNELS*WIDTH  always ~Q.
- CHANGED  out  CHANNELS  one-cycle pulse per channel whose Q changed.
- LOCKED  out  1  high when FSM is not UNLOCKED.
- ERR  out  1  one-cycle error pulse.

## Operation
- Reset (async, RST=1):
  - Every channel = RESET_VALUE; Q_BAR = ~RESET_VALUE.
  - CHANGED = 0, ERR = 0.
  - FSM = LOCKED if LOCK_ON_RESET, else UNLOCKED.
  - LOCKED reflects the FSM state.
- Write, FSM = UNLOCKED, SEL < CHANNELS:
  - EN=1: channel SEL <= D. EN has priority, so S/R masks are ignored that cycle without error.
  - EN=0, SR_EN=1, per bit: S&~R sets to 1; R&~S clears to 0; ~S&~R holds.
  - S&R follows CONFLICT_MODE: hold, 1 or 0.
  - Unselected channels always hold.
- Illegal accesses:
  - SEL >= CHANNELS with EN|SR_EN: no channel changes; ERR pulses.
  - FSM ≠ UNLOCKED with EN|SR_EN: no channel changes; ERR pulses.
- Lock FSM, states UNLOCKED, LOCKED, ARMED:
  - UNLOCKED, LOCK=1 → LOCKED. A write in the same cycle is still performed.
  - LOCKED, KEY_VALID and KEY==8'hA5 → ARMED.
  - LOCKED, KEY_VALID with any other KEY: stays LOCKED, ERR pulses.
  - ARMED, KEY_VALID and KEY==8'h5A, LOCK=0 → UNLOCKED.
  - ARMED, any other cycle → LOCKED. That covers no KEY_VALID, wrong key, or LOCK=1. Wrong key also pulses ERR.
  - LOCK has priority over key handling in every state.
  - KEY_VALID in UNLOCKED is ignored.
- CHANGED[c] = 1 iff channel c's stored value differs after the edge. A load of identical data or an S/R with no effect gives 0.

## Timing
- All state updates on the rising CLK edge, except the asynchronous reset.
- Q, Q_BAR, CHANGED, LOCKED and ERR are registered. No combinational input→output path.
- Write latency: 1 cycle. The value is visible on Q after the edge that samples EN/SR_EN.
- CHANGED and ERR are high for exactly the one cycle after the causing edge. Back-to-back causes give back-to-back pulses.
- LOCKED rises after the edge sampling LOCK=1, so a write in that edge's cycle is accepted. The first write rejected is the one in the following cycle.
- Unlocking needs two consecutive KEY_VALID cycles: A5 then 5A. LOCKED falls after the second edge, and writes are accepted from the next cycle.
- RST asserted mid-sequence (ARMED, or mid-write) aborts immediately to reset values. Outputs go to reset values without waiting for a clock edge.

## Test plan
- Reset: WIDTH=8, CHANNELS=4, RESET_VALUE=8'h3C; pulse RST → every channel Q=3C, Q_BAR=C3, CHANGED=0, ERR=0, LOCKED=0.
- Load: SEL=2, EN=1, D=8'hA5 → next cycle channel 2 = A5 and CHANGED=4'b0100. Repeat the same write → CHANGED=0.
- Set/reset conflict: channel 1 = 8'h0F; SR_EN with S=8'hF0, R=8'h3C:
  - Mode 0 → 8'hC3.
  - Mode 1 → 8'hF3.
  - Mode 2 → 8'hC3, with bits 5:4 at 0.
  - Also check EN+SR_EN in the same cycle loads D.
- Lock: LOCK=1 with EN writing 8'h11 in the same cycle → the write lands and LOCKED=1. The next write of 8'h22 → rejected, contents unchanged, ERR pulses once.
- Unlock: key A5 then 5A → LOCKED=0 after the second edge. Sequence A5, 77 → back to LOCKED with ERR. Sequence A5, idle, 5A → still LOCKED.
- Out of range and reset: SEL=3 with CHANNELS=3 → ERR, no change. Assert RST while ARMED → FSM at its reset state and channels at RESET_VALUE immediately.
